// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage load/store unit between EX/MEM and MEM/WB.
// Non-memory ops pass straight through with no added latency.
// Loads and stores run a registered req/ack handshake to a big-endian
// 32-bit data bus and hold stallreq until the access completes or aborts.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   mem_wd/wreg     destination register address / write enable in
//   mem_wdata       ALU result in
//   mem_aluop       operation code in
//   mem_addr        effective address in
//   mem_reg2        store data in
//   wd/wreg/wdata   write-back bundle to MEM/WB
//   stallreq        holds the pipeline while an access is in flight
//   misalign        pulse: misaligned access rejected, no bus cycle
//   bus_err         pulse: access aborted after TIMEOUT cycles without ack
//   bus_req/we/addr/sel/wdata  registered bus request side
//   bus_rdata/ack   bus response side
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_aluop,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_reg2,
    output logic [4:0]  wd,
    output logic        wreg,
    output logic [31:0] wdata,
    output logic        stallreq,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic [31:0]   data_q;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        sz_b;
    logic        sz_h;
    logic        sz_w;
    logic        uns;
    logic        bad_align;
    logic        start;
    logic [3:0]  sel;
    logic [31:0] sdata;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_fmt;

    // Opcode decode
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sz_b     = 1'b0;
        sz_h     = 1'b0;
        sz_w     = 1'b0;
        uns      = 1'b0;
        case (mem_aluop)
            OP_LB:  begin is_load = 1'b1; sz_b = 1'b1; end
            OP_LH:  begin is_load = 1'b1; sz_h = 1'b1; end
            OP_LW:  begin is_load = 1'b1; sz_w = 1'b1; end
            OP_LBU: begin is_load = 1'b1; sz_b = 1'b1; uns = 1'b1; end
            OP_LHU: begin is_load = 1'b1; sz_h = 1'b1; uns = 1'b1; end
            OP_SB:  begin is_store = 1'b1; sz_b = 1'b1; end
            OP_SH:  begin is_store = 1'b1; sz_h = 1'b1; end
            OP_SW:  begin is_store = 1'b1; sz_w = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem    = is_load | is_store;
    assign bad_align = (sz_h & mem_addr[0]) |
                       (sz_w & (mem_addr[1:0] != 2'b00));

    // Byte lanes: bit 3 is the most significant byte (address offset 0)
    always_comb begin
        sel   = 4'b1111;
        sdata = mem_reg2;
        if (sz_b) begin
            sdata = {4{mem_reg2[7:0]}};
            case (mem_addr[1:0])
                2'd0:    sel = 4'b1000;
                2'd1:    sel = 4'b0100;
                2'd2:    sel = 4'b0010;
                default: sel = 4'b0001;
            endcase
        end else if (sz_h) begin
            sdata = {2{mem_reg2[15:0]}};
            sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
        end
    end

    // Load alignment and extension; inputs are held stable while stalled
    always_comb begin
        case (mem_addr[1:0])
            2'd0:    ld_b = bus_rdata[31:24];
            2'd1:    ld_b = bus_rdata[23:16];
            2'd2:    ld_b = bus_rdata[15:8];
            default: ld_b = bus_rdata[7:0];
        endcase
        ld_h = mem_addr[1] ? bus_rdata[15:0] : bus_rdata[31:16];
        if (sz_b) begin
            ld_fmt = uns ? {24'd0, ld_b} : {{24{ld_b[7]}}, ld_b};
        end else if (sz_h) begin
            ld_fmt = uns ? {16'd0, ld_h} : {{16{ld_h[15]}}, ld_h};
        end else begin
            ld_fmt = bus_rdata;
        end
    end

    // Write-back bundle and control outputs
    always_comb begin
        wd       = 5'd0;
        wreg     = 1'b0;
        wdata    = 32'd0;
        stallreq = 1'b0;
        misalign = 1'b0;
        bus_err  = 1'b0;
        start    = 1'b0;
        if (!rst) begin
            wd = mem_wd;
            case (state)
                S_IDLE: begin
                    // The cycle after an abort lets the faulted op
                    // leave the pipeline instead of retrying it.
                    if (err_q) begin
                        bus_err = 1'b1;
                    end else if (!is_mem) begin
                        wreg  = mem_wreg;
                        wdata = mem_wdata;
                    end else if (bad_align) begin
                        misalign = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                        start    = 1'b1;
                    end
                end
                S_BUS: begin
                    stallreq = 1'b1;
                end
                S_DONE: begin
                    if (is_load) begin
                        wreg  = mem_wreg;
                        wdata = data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            err_q     <= 1'b0;
            data_q    <= 32'd0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_sel   <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_BUS;
                        cnt       <= '0;
                        bus_req   <= 1'b1;
                        bus_we    <= is_store;
                        bus_addr  <= {mem_addr[31:2], 2'b00};
                        bus_sel   <= sel;
                        bus_wdata <= sdata;
                    end
                end
                S_BUS: begin
                    // Ack takes priority over the timeout on the same edge
                    if (bus_ack) begin
                        data_q  <= ld_fmt;
                        bus_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (cnt == CNT_LAST) begin
                        bus_req <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu.
// Linear directed steps with immediate assertions at each check point.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_addr;
    logic [31:0] mem_reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        stallreq;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int checks = 0;
    int errors = 0;
    int stall_n;
    int req_n;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_sel;
    logic        cap_we;

    mem_lsu #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_aluop (mem_aluop),
        .mem_addr  (mem_addr),
        .mem_reg2  (mem_reg2),
        .wd        (wd),
        .wreg      (wreg),
        .wdata     (wdata),
        .stallreq  (stallreq),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_sel   (bus_sel),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] op, input logic [4:0] rd,
                          input logic we, input logic [31:0] addr,
                          input logic [31:0] r2, input logic [31:0] res);
        mem_aluop = op;
        mem_wd    = rd;
        mem_wreg  = we;
        mem_addr  = addr;
        mem_reg2  = r2;
        mem_wdata = res;
        #1;
    endtask

    // Runs one access from its first IDLE cycle until stallreq drops.
    // ack_at = index of the bus cycle that gets ack (0 = never).
    task automatic run_access(input int ack_at, input logic [31:0] rd);
        stall_n = 0;
        req_n   = 0;
        for (int c = 0; c < 40; c++) begin
            if (stallreq) stall_n++;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    cap_addr  = bus_addr;
                    cap_wdata = bus_wdata;
                    cap_sel   = bus_sel;
                    cap_we    = bus_we;
                end
            end
            bus_ack   = bus_req && (req_n == ack_at);
            bus_rdata = bus_ack ? rd : 32'hDEADBEEF;
            if (!stallreq) break;
            tick();
        end
        bus_ack = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = 32'd0;
        set_op(8'hE3, 5'd9, 1'b1, 32'h100, 32'h0, 32'h55);
        tick();
        tick();
        chk("rst_wd", 32'(wd), 0);
        chk("rst_wreg", 32'(wreg), 0);
        chk("rst_stall", 32'(stallreq), 0);
        chk("rst_req", 32'(bus_req), 0);
        chk("rst_sel", 32'(bus_sel), 0);
        chk("rst_addr", bus_addr, 0);

        // ALU passthrough
        rst = 1'b0;
        set_op(8'h21, 5'd5, 1'b1, 32'h0, 32'h0, 32'h1234);
        chk("alu_wd", 32'(wd), 5);
        chk("alu_wreg", 32'(wreg), 1);
        chk("alu_wdata", wdata, 32'h1234);
        chk("alu_stall", 32'(stallreq), 0);
        chk("alu_req", 32'(bus_req), 0);

        // LB addr 0x101, ack on 3rd bus cycle
        set_op(8'hE0, 5'd7, 1'b1, 32'h101, 32'h0, 32'h0);
        chk("lb_stall0", 32'(stallreq), 1);
        chk("lb_wreg0", 32'(wreg), 0);
        run_access(3, 32'h0080FF00);
        chk("lb_stalln", 32'(stall_n), 4);
        chk("lb_sel", 32'(cap_sel), 32'b0100);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_we", 32'(cap_we), 0);
        chk("lb_wreg", 32'(wreg), 1);
        chk("lb_wd", 32'(wd), 7);
        chk("lb_wdata", wdata, 32'hFFFFFF80);
        tick();

        // Ack outside BUS is ignored
        set_op(8'h21, 5'd3, 1'b1, 32'h0, 32'h0, 32'h77);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("idle_ack_req", 32'(bus_req), 0);
        chk("idle_ack_wd", wdata, 32'h77);

        // SH addr 0x202, ack on 1st bus cycle
        set_op(8'hE9, 5'd4, 1'b1, 32'h202, 32'hABCD1234, 32'h0);
        run_access(1, 32'h0);
        chk("sh_stalln", 32'(stall_n), 2);
        chk("sh_we", 32'(cap_we), 1);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_sel", 32'(cap_sel), 32'b0011);
        chk("sh_wdata", cap_wdata, 32'h12341234);
        chk("sh_wreg", 32'(wreg), 0);
        tick();

        // SB addr 0x303
        set_op(8'hE8, 5'd4, 1'b1, 32'h303, 32'h000000AB, 32'h0);
        run_access(2, 32'h0);
        chk("sb_sel", 32'(cap_sel), 32'b0001);
        chk("sb_wdata", cap_wdata, 32'hABABABAB);
        tick();

        // LHU / LH / LBU formatting
        set_op(8'hE5, 5'd6, 1'b1, 32'h100, 32'h0, 32'h0);
        run_access(1, 32'h8001F00D);
        chk("lhu_sel", 32'(cap_sel), 32'b1100);
        chk("lhu_wdata", wdata, 32'h00008001);
        tick();
        set_op(8'hE1, 5'd6, 1'b1, 32'h102, 32'h0, 32'h0);
        run_access(1, 32'h8001F00D);
        chk("lh_wdata", wdata, 32'hFFFFF00D);
        tick();
        set_op(8'hE4, 5'd6, 1'b1, 32'h100, 32'h0, 32'h0);
        run_access(1, 32'h9A000000);
        chk("lbu_sel", 32'(cap_sel), 32'b1000);
        chk("lbu_wdata", wdata, 32'h0000009A);
        tick();

        // Misaligned LW
        set_op(8'hE3, 5'd8, 1'b1, 32'h102, 32'h0, 32'h0);
        chk("mis_pulse", 32'(misalign), 1);
        chk("mis_stall", 32'(stallreq), 0);
        chk("mis_wreg", 32'(wreg), 0);
        tick();
        chk("mis_req", 32'(bus_req), 0);
        set_op(8'h21, 5'd1, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("mis_end", 32'(misalign), 0);

        // LW timeout
        set_op(8'hE3, 5'd10, 1'b1, 32'h300, 32'h0, 32'h0);
        run_access(0, 32'h0);
        chk("to_req_n", 32'(req_n), 16);
        chk("to_stalln", 32'(stall_n), 17);
        chk("to_err", 32'(bus_err), 1);
        chk("to_stall", 32'(stallreq), 0);
        chk("to_wreg", 32'(wreg), 0);
        chk("to_req", 32'(bus_req), 0);
        tick();
        set_op(8'h21, 5'd1, 1'b0, 32'h0, 32'h0, 32'h0);
        chk("to_err_end", 32'(bus_err), 0);

        // LW ack on the 16th bus cycle completes normally
        set_op(8'hE3, 5'd11, 1'b1, 32'h300, 32'h0, 32'h0);
        run_access(16, 32'hCAFEBABE);
        chk("tb_req_n", 32'(req_n), 16);
        chk("tb_err", 32'(bus_err), 0);
        chk("tb_wreg", 32'(wreg), 1);
        chk("tb_wdata", wdata, 32'hCAFEBABE);
        tick();

        // Reset while in BUS
        set_op(8'hE3, 5'd12, 1'b1, 32'h400, 32'h0, 32'h0);
        tick();
        tick();
        chk("rb_req_on", 32'(bus_req), 1);
        rst = 1'b1;
        #1;
        chk("rb_stall", 32'(stallreq), 0);
        tick();
        chk("rb_req_off", 32'(bus_req), 0);
        rst = 1'b0;
        set_op(8'h21, 5'd2, 1'b1, 32'h0, 32'h0, 32'h99);
        bus_ack   = 1'b1;
        bus_rdata = 32'h11111111;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("rb_req_late", 32'(bus_req), 0);
        chk("rb_stall_late", 32'(stallreq), 0);
        chk("rb_wdata", wdata, 32'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
